// File: rtl/syncregs_pkg.sv
// Shared helpers for the syncregs_filt synchroniser/filter block.
package syncregs_pkg;

  function automatic int cnt_width(input int filt_cycles);
    return (filt_cycles <= 1) ? 1 : $clog2(filt_cycles);
  endfunction

  function automatic bit params_ok(input int depth, input int filt_cycles);
    return (depth >= 2) && (filt_cycles >= 1);
  endfunction

endpackage

// File: rtl/syncregs_filt_chan.sv
// One channel of syncregs_filt: stability filter, change-edge pulses and,
// with SYNCREGS_FILT_STICKY_EN defined, a latched change flag.
module syncregs_filt_chan
  import syncregs_pkg::*;
#(
  parameter int   FILT_CYCLES = 4,
  parameter logic RST_BIT     = 1'b0
) (
  input  logic clk,
  input  logic arst,
  input  logic i_s,
`ifdef SYNCREGS_FILT_STICKY_EN
  input  logic i_sticky_clr,
  output logic o_sticky,
`endif
  output logic o_dout,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW       = cnt_width(FILT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_CYCLES - 1);

  logic [CW-1:0] r_cnt;
  logic          r_dout;
  logic          r_rise;
  logic          r_fall;
  logic          w_diff;
  logic          w_accept;

  assign w_diff   = (i_s != r_dout);
  assign w_accept = w_diff && (r_cnt == CNT_LAST);

  // Any return of s to dout restarts the count, rejecting short glitches.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_cnt  <= '0;
      r_dout <= RST_BIT;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_rise <= w_accept & i_s;
      r_fall <= w_accept & ~i_s;
      if (!w_diff) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_dout <= i_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_dout = r_dout;
  assign o_rise = r_rise;
  assign o_fall = r_fall;

`ifdef SYNCREGS_FILT_STICKY_EN
  logic r_sticky;

  // A pending event beats a simultaneous clear so no change is lost.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sticky <= 1'b0;
    end else if (r_rise | r_fall) begin
      r_sticky <= 1'b1;
    end else if (i_sticky_clr) begin
      r_sticky <= 1'b0;
    end
  end

  assign o_sticky = r_sticky;
`endif

endmodule

// File: rtl/syncregs_filt.sv
// Multi-channel level synchroniser with per-channel stability filter and edge
// events. Optional sticky change flags are enabled by SYNCREGS_FILT_STICKY_EN.
module syncregs_filt
  import syncregs_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter int               DEPTH       = 3,
  parameter int               FILT_CYCLES = 4,
  parameter logic [WIDTH-1:0] RST_VAL     = '0
) (
  input  logic             clk,
  input  logic             arst,
  input  logic [WIDTH-1:0] din,
`ifdef SYNCREGS_FILT_STICKY_EN
  input  logic             sticky_clr,
  output logic [WIDTH-1:0] sticky,
`endif
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  if (!params_ok(DEPTH, FILT_CYCLES)) begin : g_param_err
    $error("syncregs_filt: DEPTH must be >= 2 and FILT_CYCLES >= 1");
  end

  // Single WIDTH x DEPTH block so one name pattern covers the CDC constraint;
  // index 0 is the metastability stage.
  (* async_reg = "true" *) logic [DEPTH-1:0][WIDTH-1:0] r_sync;
  logic [WIDTH-1:0] w_s;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_sync <= {DEPTH{RST_VAL}};
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], din};
    end
  end

  assign w_s = r_sync[DEPTH-1];

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    syncregs_filt_chan #(
      .FILT_CYCLES (FILT_CYCLES),
      .RST_BIT     (RST_VAL[i])
    ) u_chan (
      .clk          (clk),
      .arst         (arst),
      .i_s          (w_s[i]),
`ifdef SYNCREGS_FILT_STICKY_EN
      .i_sticky_clr (sticky_clr),
      .o_sticky     (sticky[i]),
`endif
      .o_dout       (dout[i]),
      .o_rise       (rise[i]),
      .o_fall       (fall[i])
    );
  end

endmodule

// File: tb/tb_syncregs_filt.sv
// Scoreboard bench for syncregs_filt: random and directed stimulus against a
// delay-line + run-length reference model, plus a DEPTH=2/FILT=1 instance.
module tb_syncregs_filt;

  localparam int         W    = 4;
  localparam int         DEP  = 3;
  localparam int         FILT = 4;
  localparam logic [3:0] RSTV = 4'h0;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic [3:0] din = '0;
  logic       sticky_clr = 1'b0;
  logic [3:0] sticky;
  logic [3:0] dout, rise, fall;

  logic       arst2 = 1'b1;
  logic [3:0] din2 = '0;
  logic       sticky_clr2 = 1'b0;
  logic [3:0] sticky2;
  logic [3:0] dout2, rise2, fall2;

  always #5 clk = ~clk;

  syncregs_filt #(.WIDTH(W), .DEPTH(DEP), .FILT_CYCLES(FILT), .RST_VAL(RSTV)) dut (
    .clk        (clk),
    .arst       (arst),
    .din        (din),
`ifdef SYNCREGS_FILT_STICKY_EN
    .sticky_clr (sticky_clr),
    .sticky     (sticky),
`endif
    .dout       (dout),
    .rise       (rise),
    .fall       (fall)
  );

  syncregs_filt #(.WIDTH(4), .DEPTH(2), .FILT_CYCLES(1), .RST_VAL(4'hA)) dut2 (
    .clk        (clk),
    .arst       (arst2),
    .din        (din2),
`ifdef SYNCREGS_FILT_STICKY_EN
    .sticky_clr (sticky_clr2),
    .sticky     (sticky2),
`endif
    .dout       (dout2),
    .rise       (rise2),
    .fall       (fall2)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: s is din delayed DEPTH edges; the filter sees the
  // pre-edge s and accepts a new value once it has persisted FILT edges.
  typedef struct {
    logic [3:0] dout;
    logic [3:0] rise;
    logic [3:0] fall;
    logic [3:0] stk;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [3:0] m_line[$];
  logic [3:0] m_dout, m_rise, m_fall, m_stk, m_last;
  int         m_run[4];

  function void model_reset();
    m_line.delete();
    for (int k = 0; k < DEP; k++) m_line.push_back(RSTV);
    m_dout = RSTV;
    m_rise = '0;
    m_fall = '0;
    m_stk  = '0;
    m_last = RSTV;
    for (int k = 0; k < 4; k++) m_run[k] = 0;
  endfunction

  function void model_edge(input logic [3:0] d, input logic clr);
    logic [3:0] f, nr, nf, nstk;
    f = m_line.pop_front();
    m_line.push_back(d);
    nstk = (m_stk & ~{4{clr}}) | m_rise | m_fall;
    nr = '0;
    nf = '0;
    for (int k = 0; k < 4; k++) begin
      m_run[k] = (f[k] == m_last[k]) ? m_run[k] + 1 : 1;
      if (f[k] != m_dout[k] && m_run[k] >= FILT) begin
        m_dout[k] = f[k];
        nr[k] = f[k];
        nf[k] = ~f[k];
      end
    end
    m_last = f;
    m_rise = nr;
    m_fall = nf;
    m_stk  = nstk;
  endfunction

  task automatic step(input logic [3:0] d, input logic clr, input logic rst);
    exp_t e;
    @(negedge clk);
    din = d;
    sticky_clr = clr;
    if (rst) begin
      arst = 1'b1;
      model_reset();
      #1;
      chk("reset_now_dout", dout, 0);
      chk("reset_now_rise", rise, 0);
      chk("reset_now_fall", fall, 0);
    end else begin
      arst = 1'b0;
      model_edge(d, clr);
    end
    e = '{m_dout, m_rise, m_fall, m_stk};
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Runs n edges with fixed inputs, counting pulses on one bit.
  task automatic run(input logic [3:0] d, input logic clr, input int n, input int b,
                     output int nr, output int nf, output int fr, output int ff,
                     output logic [3:0] rise_at);
    nr = 0; nf = 0; fr = -1; ff = -1; rise_at = '0;
    for (int e = 1; e <= n; e++) begin
      step(d, clr, 1'b0);
      #1;
      if (rise[b]) begin
        nr++;
        if (fr < 0) begin fr = e; rise_at = rise; end
      end
      if (fall[b]) begin
        nf++;
        if (ff < 0) ff = e;
      end
    end
  endtask

  // Monitor: every DUT edge with a pending expectation is compared.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("sb_dout", dout, mon_e.dout);
        chk("sb_rise", rise, mon_e.rise);
        chk("sb_fall", fall, mon_e.fall);
        chk("sb_rise_and_fall", rise & fall, 0);
`ifdef SYNCREGS_FILT_STICKY_EN
        chk("sb_sticky", sticky, mon_e.stk);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int nr, nf, fr, ff, tot;
    logic [3:0] ra, rd;
    int hold[4];
    bit seen;
    model_reset();

    // Reset held with all inputs high, then release.
    for (int c = 0; c < 10; c++) step(4'hF, 1'b0, 1'b1);
    run(4'hF, 1'b0, 12, 0, nr, nf, fr, ff, ra);
    chk("t1_latency", fr, 7);
    chk("t1_rise_all", ra, 4'hF);
    chk("t1_rise_count", nr, 1);
    run(4'h0, 1'b0, 12, 0, nr, nf, fr, ff, ra);

    // Short pulse rejected, pulse of FILT cycles accepted.
    run(4'h1, 1'b0, 3, 0, nr, nf, fr, ff, ra);
    tot = nr;
    run(4'h0, 1'b0, 12, 0, nr, nf, fr, ff, ra);
    chk("t2_short_no_rise", tot + nr, 0);
    run(4'h1, 1'b0, 4, 0, nr, nf, fr, ff, ra);
    tot = nr;
    run(4'h0, 1'b0, 12, 0, nr, nf, fr, ff, ra);
    chk("t2_pulse_rise_count", tot + nr, 1);
    chk("t2_pulse_rise_edge", fr, 3);
    chk("t2_pulse_fall_edge", ff, 7);

    // Bit 1 toggles with 2-cycle spacing, then holds.
    tot = 0;
    run(4'h2, 1'b0, 2, 1, nr, nf, fr, ff, ra); tot += nr;
    run(4'h0, 1'b0, 2, 1, nr, nf, fr, ff, ra); tot += nr;
    run(4'h2, 1'b0, 12, 1, nr, nf, fr, ff, ra);
    chk("t3_single_rise", tot + nr, 1);
    chk("t3_rise_edge", fr, 7);
    run(4'h0, 1'b0, 12, 1, nr, nf, fr, ff, ra);

`ifdef SYNCREGS_FILT_STICKY_EN
    // Event on bit 2 coincident with clear: set wins, then clear.
    seen = 1'b0;
    for (int c = 0; c < 12 && !seen; c++) begin
      step(4'h4, 1'b1, 1'b0);
      #1;
      seen = rise[2];
    end
    chk("t4_rise_seen", seen, 1);
    step(4'h4, 1'b1, 1'b0);
    #1;
    chk("t4_sticky_set_wins", sticky[2], 1);
    step(4'h4, 1'b1, 1'b0);
    #1;
    chk("t4_sticky_cleared", sticky, 0);
    run(4'h0, 1'b0, 12, 2, nr, nf, fr, ff, ra);
`endif

    // Reset in mid-count discards it; full latency applies again.
    run(4'h8, 1'b0, 5, 3, nr, nf, fr, ff, ra);
    step(4'h8, 1'b0, 1'b1);
    step(4'h8, 1'b0, 1'b1);
    run(4'h8, 1'b0, 12, 3, nr, nf, fr, ff, ra);
    chk("t5_latency_after_reset", fr, 7);
    chk("t5_rise_count", nr, 1);

    // Randomised phase with random holds, clears and occasional resets.
    rd = din;
    for (int k = 0; k < 4; k++) hold[k] = 0;
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 4; k++) begin
        if (hold[k] == 0) begin
          rd[k] = 1'($urandom_range(0, 1));
          hold[k] = int'($urandom_range(1, 9));
        end
        hold[k]--;
      end
      step(rd, ($urandom_range(0, 5) == 0), ($urandom_range(0, 149) == 0));
    end
    for (int c = 0; c < 12; c++) step(rd, 1'b0, 1'b0);
    #2;
    chk("sb_queue_drained", exp_q.size(), 0);

    // DEPTH=2, FILT_CYCLES=1, RST_VAL=A instance.
    @(negedge clk);
    arst2 = 1'b1;
    din2 = 4'h5;
    #1;
    chk("t6_reset_dout", dout2, 4'hA);
    @(negedge clk);
    arst2 = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge clk);
      #1;
      if (e < 3) begin
        chk("t6_dout_early", dout2, 4'hA);
        chk("t6_rise_early", rise2 | fall2, 0);
      end else if (e == 3) begin
        chk("t6_dout_edge3", dout2, 4'h5);
        chk("t6_rise_edge3", rise2, 4'h5);
        chk("t6_fall_edge3", fall2, 4'hA);
      end else begin
        chk("t6_dout_hold", dout2, 4'h5);
        chk("t6_pulse_end", rise2 | fall2, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
